// File: rtl/bus_width_mux_pkg.sv
// Shared definitions for the wide-to-narrow bus multiplexer: FSM encodings,
// counter width and the lane-count derivation used by the decoder and bus fabric.
package bus_width_mux_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BEAT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Wait-state counter covers the full 0..15 range.
  localparam int CNT_BITS = 4;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // A single-lane bus still needs a one-bit lane port.
  function automatic int lane_bits(input int ratio);
    return (clog2(ratio) < 1) ? 1 : clog2(ratio);
  endfunction

endpackage

// File: rtl/bus_width_mux.sv
// Splits one CPU_WIDTH memory access into RATIO narrow beats with wait states,
// sysrdy stretching and a selectable lane order; ready is held low until done.
module bus_width_mux
  import bus_width_mux_pkg::*;
#(
  parameter int CPU_WIDTH    = 16,
  parameter int NARROW_WIDTH = 8,
  parameter int WAIT_STATES  = 4,
  parameter bit LOW_FIRST    = 1'b1
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             clk_en,
  input  logic                                             memen,
  input  logic                                             start,
  input  logic                                             we,
  input  logic                                             sysrdy,
  input  logic [CPU_WIDTH-1:0]                             q,
  input  logic [NARROW_WIDTH-1:0]                          d8,
  output logic                                             ready,
  output logic                                             narrow_en,
  output logic [lane_bits(CPU_WIDTH / NARROW_WIDTH)-1:0]   lane,
  output logic [NARROW_WIDTH-1:0]                          q8,
  output logic [CPU_WIDTH-1:0]                             d,
  output logic                                             busy
);

  localparam int RATIO     = CPU_WIDTH / NARROW_WIDTH;
  localparam int LANE_BITS = lane_bits(RATIO);

  localparam logic [LANE_BITS-1:0] FIRST_LANE = LOW_FIRST ? LANE_BITS'(RATIO - 1) : '0;
  localparam logic [LANE_BITS-1:0] LAST_LANE  = LOW_FIRST ? '0 : LANE_BITS'(RATIO - 1);
  localparam logic [CNT_BITS-1:0]  WAIT_INIT  = CNT_BITS'(WAIT_STATES);

  logic [1:0]           state_reg, state_next;
  logic [CNT_BITS-1:0]  cnt_reg, cnt_next;
  logic [LANE_BITS-1:0] lane_reg, lane_next;
  logic                 start_access;
  logic                 capture_en;

  logic [NARROW_WIDTH-1:0] q_lane [RATIO];
  logic [RATIO-1:0]        lane_hit;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    lane_next    = lane_reg;
    start_access = 1'b0;
    capture_en   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (memen && start) begin
          start_access = 1'b1;
          state_next   = ST_BEAT;
          cnt_next     = WAIT_INIT;
          lane_next    = FIRST_LANE;
        end
      end
      ST_BEAT: begin
        if (!memen) begin
          state_next = ST_IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (sysrdy) begin
          capture_en = !we;
          if (lane_reg == LAST_LANE) begin
            state_next = ST_DONE;
          end else begin
            lane_next = LOW_FIRST ? lane_reg - 1'b1 : lane_reg + 1'b1;
            cnt_next  = WAIT_INIT;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      lane_reg  <= FIRST_LANE;
    end else if (clk_en) begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      lane_reg  <= lane_next;
    end
  end

  // Lane 0 is the numerically most significant slice (CPU numbers bit 0 as MSB).
  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      localparam int LO = (RATIO - 1 - gi) * NARROW_WIDTH;
      logic [NARROW_WIDTH-1:0] byte_reg;

      assign q_lane[gi]              = q[LO +: NARROW_WIDTH];
      assign lane_hit[gi]            = (lane_reg == LANE_BITS'(gi));
      assign d[LO +: NARROW_WIDTH]   = byte_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          byte_reg <= '1;
        end else if (clk_en) begin
          if (start_access) begin
            byte_reg <= '1;
          end else if (capture_en && lane_hit[gi]) begin
            byte_reg <= d8;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    q8 = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_hit[i]) q8 = q_lane[i];
    end
  end

  assign lane      = lane_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign narrow_en = (state_reg == ST_BEAT);
  assign ready     = (state_reg == ST_IDLE) ? !(memen && start) : (state_reg == ST_DONE);

endmodule
